// File: rtl/dram_req_sched.sv
// Row-hit-first request scheduler in front of the row-buffered DRAM model.
// Requests queue in age order; one request is outstanding at a time, and a starvation cap bounds reordering.
module dram_req_sched #(
    parameter int DEPTH      = 4,
    parameter int ROW_W      = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int MAX_BYPASS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ROW_W-1:0]  req_rno,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              mem_valid,
    output logic [ROW_W-1:0]  mem_rno,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_y,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_hit,
    output logic              busy
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BYP_W = (MAX_BYPASS > 0) ? $clog2(MAX_BYPASS + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   rno_q [DEPTH];
    logic [ROW_W-1:0]   rno_d [DEPTH];
    logic [TAG_W-1:0]   tag_q [DEPTH];
    logic [TAG_W-1:0]   tag_d [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d, cnt_mid;
    logic [ROW_W-1:0]   open_row_q, open_row_d;
    logic               open_vld_q, open_vld_d;
    logic [BYP_W-1:0]   bypass_q, bypass_d;
    logic [TAG_W-1:0]   lat_tag_q, lat_tag_d;
    logic               lat_hit_q, lat_hit_d;
    logic               mem_valid_q, mem_valid_d;
    logic [ROW_W-1:0]   mem_rno_q, mem_rno_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   first_hit, sel_idx;
    logic               any_hit, sel_hit, enq;

    assign req_ready = (count_q < CNT_W'(DEPTH));
    assign enq       = req_valid && req_ready;

    // Oldest valid entry matching the open row; the cap forces the head once it has been overtaken enough.
    always_comb begin
        first_hit = '0;
        any_hit   = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (open_vld_q && (CNT_W'(i) < count_q) && (rno_q[i] == open_row_q)) begin
                first_hit = IDX_W'(i);
                any_hit   = 1'b1;
            end
        end
        sel_idx = ((bypass_q == BYP_W'(MAX_BYPASS)) || !any_hit) ? '0 : first_hit;
        sel_hit = open_vld_q && (rno_q[sel_idx] == open_row_q);
    end

    always_comb begin
        state_d     = state_q;
        rno_d       = rno_q;
        tag_d       = tag_q;
        cnt_mid     = count_q;
        open_row_d  = open_row_q;
        open_vld_d  = open_vld_q;
        bypass_d    = bypass_q;
        lat_tag_d   = lat_tag_q;
        lat_hit_d   = lat_hit_q;
        mem_valid_d = 1'b0;
        mem_rno_d   = mem_rno_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_hit_d   = rsp_hit_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        if (IDX_W'(i) >= sel_idx) begin
                            rno_d[i] = rno_q[i+1];
                            tag_d[i] = tag_q[i+1];
                        end
                    end
                    cnt_mid     = count_q - CNT_W'(1);
                    bypass_d    = (sel_idx != '0) ? bypass_q + BYP_W'(1) : '0;
                    lat_tag_d   = tag_q[sel_idx];
                    lat_hit_d   = sel_hit;
                    open_row_d  = rno_q[sel_idx];
                    open_vld_d  = 1'b1;
                    mem_valid_d = 1'b1;
                    mem_rno_d   = rno_q[sel_idx];
                    busy_d      = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // mem_done seen at this edge still belongs to the previous access.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mem_y;
                    rsp_tag_d   = lat_tag_q;
                    rsp_hit_d   = lat_hit_q;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enq) begin
            rno_d[cnt_mid[IDX_W-1:0]] = req_rno;
            tag_d[cnt_mid[IDX_W-1:0]] = req_tag;
        end
        count_d = cnt_mid + CNT_W'(enq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rno_q       <= '{default: '0};
            tag_q       <= '{default: '0};
            count_q     <= '0;
            open_row_q  <= '0;
            open_vld_q  <= 1'b0;
            bypass_q    <= '0;
            lat_tag_q   <= '0;
            lat_hit_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rno_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_hit_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rno_q       <= rno_d;
            tag_q       <= tag_d;
            count_q     <= count_d;
            open_row_q  <= open_row_d;
            open_vld_q  <= open_vld_d;
            bypass_q    <= bypass_d;
            lat_tag_q   <= lat_tag_d;
            lat_hit_q   <= lat_hit_d;
            mem_valid_q <= mem_valid_d;
            mem_rno_q   <= mem_rno_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_hit_q   <= rsp_hit_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_rno   = mem_rno_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_hit   = rsp_hit_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dram_req_sched.sv
// Bench for dram_req_sched: queue-based reference model, scoreboard monitor and a simple DRAM stand-in.
module tb_dram_req_sched;
    localparam int DEPTH = 4, ROW_W = 4, DATA_W = 32, TAG_W = 4, MAX_BYPASS = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ROW_W-1:0]  req_rno = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic              mem_valid;
    logic [ROW_W-1:0]  mem_rno;
    logic              mem_done;
    logic [DATA_W-1:0] mem_y;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_hit;
    logic              busy;

    dram_req_sched #(.DEPTH(DEPTH), .ROW_W(ROW_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
                     .MAX_BYPASS(MAX_BYPASS)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rno(req_rno), .req_tag(req_tag), .mem_valid(mem_valid), .mem_rno(mem_rno),
        .mem_done(mem_done), .mem_y(mem_y), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_hit(rsp_hit), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // DRAM stand-in: done drops on issue, rises after a latency (short on a row hit) and then stays high.
    logic             hold = 1'b0;
    logic             d_done = 1'b0;
    logic [ROW_W-1:0] d_row = '0;
    logic [ROW_W-1:0] d_open = '0;
    logic             d_open_vld = 1'b0;
    int               d_cnt = 0;

    always @(posedge clk) begin
        if (mem_valid) begin
            d_done     <= 1'b0;
            d_row      <= mem_rno;
            d_cnt      <= (d_open_vld && mem_rno == d_open) ? 2 : 3 + int'($urandom_range(0, 4));
            d_open     <= mem_rno;
            d_open_vld <= 1'b1;
        end else if (d_cnt > 0 && !hold) begin
            if (d_cnt == 1) d_done <= 1'b1;
            d_cnt <= d_cnt - 1;
        end
    end
    assign mem_done = d_done;
    assign mem_y    = DATA_W'(d_row);

    typedef struct { logic [ROW_W-1:0] rno; logic [TAG_W-1:0] tag; } ent_t;
    typedef struct { logic [TAG_W-1:0] tag; logic [DATA_W-1:0] data; logic hit; } rsp_t;

    ent_t             mq[$];
    rsp_t             exp_q[$];
    rsp_t             log_q[$];
    int               m_phase = 0;      // 0 idle, 1 issuing, 2 waiting for the DRAM
    logic [ROW_W-1:0] m_open = '0;
    logic [ROW_W-1:0] m_issue_rno = '0;
    logic             m_open_vld = 1'b0;
    int               m_byp = 0;
    int               rsp_cnt = 0;

    // Reference model: row-hit-first with a bypass cap, applied to an age-ordered list.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_phase    = 0;
            m_open_vld = 1'b0;
            m_byp      = 0;
        end else begin
            bit can_take;
            int h;
            int pick;
            rsp_t r;
            can_take = (mq.size() < DEPTH);
            if (m_phase == 0) begin
                if (mq.size() > 0) begin
                    h = -1;
                    foreach (mq[i]) if (h < 0 && m_open_vld && mq[i].rno == m_open) h = i;
                    pick = (m_byp == MAX_BYPASS || h < 0) ? 0 : h;
                    m_byp = (pick != 0) ? m_byp + 1 : 0;
                    r.tag  = mq[pick].tag;
                    r.data = DATA_W'(mq[pick].rno);
                    r.hit  = m_open_vld && (mq[pick].rno == m_open);
                    exp_q.push_back(r);
                    m_issue_rno = mq[pick].rno;
                    m_open      = mq[pick].rno;
                    m_open_vld  = 1'b1;
                    mq.delete(pick);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (mem_done) begin
                m_phase = 0;
            end
            if (req_valid && can_take) mq.push_back('{req_rno, req_tag});
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            rsp_t e;
            rsp_t a;
            chk("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("mem_valid", 32'(mem_valid), 32'(m_phase == 1));
            if (mem_valid) chk("mem_rno", 32'(mem_rno), 32'(m_issue_rno));
            if (rsp_valid) begin
                rsp_cnt++;
                a.tag = rsp_tag; a.data = rsp_data; a.hit = rsp_hit;
                log_q.push_back(a);
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_tag), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
                end
            end
        end
    end

    task automatic send(input logic [ROW_W-1:0] r, input logic [TAG_W-1:0] t);
        int  n;
        bit  acc;
        n = 0;
        req_valid = 1'b1; req_rno = r; req_tag = t;
        forever begin
            acc = req_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) break;
            if (++n > 500) begin
                chk("send_timeout", 32'(n), 32'd0);
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && m_phase == 0 && mq.size() == 0)) begin
            @(negedge clk);
            if (++n > 2000) begin
                chk("drain_timeout", 32'(exp_q.size()), 32'd0);
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tagname);
        chk({tagname, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tagname, "_mem_rno"},   32'(mem_rno),   32'd0);
        chk({tagname, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tagname, "_rsp_data"},  rsp_data,       32'd0);
        chk({tagname, "_rsp_tag"},   32'(rsp_tag),   32'd0);
        chk({tagname, "_rsp_hit"},   32'(rsp_hit),   32'd0);
        chk({tagname, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt0;
        logic [TAG_W-1:0] exp_tags [6];
        logic             exp_hits [6];

        repeat (3) @(negedge clk);
        chk_outputs_zero("rst_init");
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Single request from a closed row.
        base = log_q.size();
        send(4'd5, 4'd1);
        wait_idle();
        chk("single_count", 32'(log_q.size() - base), 32'd1);
        if (log_q.size() > base) begin
            chk("single_tag",  32'(log_q[base].tag), 32'd1);
            chk("single_data", log_q[base].data,     32'd5);
            chk("single_hit",  32'(log_q[base].hit), 32'd0);
        end

        // Reorder: row 3 open, then [(7,4),(3,5),(3,6)] -> 5,6,4.
        hold = 1'b1;
        base = log_q.size();
        send(4'd3, 4'd0);
        send(4'd7, 4'd4); send(4'd3, 4'd5); send(4'd3, 4'd6);
        hold = 1'b0;
        wait_idle();
        exp_tags[0:2] = '{4'd5, 4'd6, 4'd4};
        exp_hits[0:2] = '{1'b1, 1'b1, 1'b0};
        chk("reorder_count", 32'(log_q.size() - base), 32'd4);
        for (int i = 0; i < 3; i++) if (log_q.size() > base + 1 + i) begin
            chk("reorder_tag", 32'(log_q[base+1+i].tag), 32'(exp_tags[i]));
            chk("reorder_hit", 32'(log_q[base+1+i].hit), 32'(exp_hits[i]));
        end

        // Starvation cap: [(7,8),(3,9),(3,10),(3,11)] with row 3 open -> 9,10,8,11.
        hold = 1'b1;
        base = log_q.size();
        send(4'd3, 4'd7);
        send(4'd7, 4'd8); send(4'd3, 4'd9); send(4'd3, 4'd10); send(4'd3, 4'd11);
        hold = 1'b0;
        wait_idle();
        exp_tags[0:3] = '{4'd9, 4'd10, 4'd8, 4'd11};
        exp_hits[0:3] = '{1'b1, 1'b1, 1'b0, 1'b0};
        chk("starve_count", 32'(log_q.size() - base), 32'd5);
        for (int i = 0; i < 4; i++) if (log_q.size() > base + 1 + i) begin
            chk("starve_tag", 32'(log_q[base+1+i].tag), 32'(exp_tags[i]));
            chk("starve_hit", 32'(log_q[base+1+i].hit), 32'(exp_hits[i]));
        end

        // Full queue while the DRAM is held.
        hold = 1'b1;
        base = log_q.size();
        send(4'd1, 4'd0);
        send(4'd2, 4'd1); send(4'd2, 4'd2); send(4'd2, 4'd3); send(4'd2, 4'd4);
        repeat (2) @(negedge clk);
        chk("full_ready", 32'(req_ready), 32'd0);
        fork
            send(4'd2, 4'd5);
            begin repeat (6) @(negedge clk); hold = 1'b0; end
        join
        wait_idle();
        chk("full_count", 32'(log_q.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) if (log_q.size() > base + i)
            chk("full_tag", 32'(log_q[base+i].tag), 32'(i));

        // Reset while waiting on the DRAM.
        hold = 1'b1;
        send(4'd6, 4'd12);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_outputs_zero("rst_wait");
        chk("rst_wait_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cnt0 = rsp_cnt;
        repeat (12) @(negedge clk);
        chk("rst_no_rsp", 32'(rsp_cnt - cnt0), 32'd0);
        base = log_q.size();
        send(4'd6, 4'd13);
        wait_idle();
        chk("rst_next_count", 32'(log_q.size() - base), 32'd1);
        if (log_q.size() > base) begin
            chk("rst_next_tag", 32'(log_q[base].tag), 32'd13);
            chk("rst_next_hit", 32'(log_q[base].hit), 32'd0);
        end

        // Randomized traffic over a few rows so hits, misses and the cap all occur.
        for (int k = 0; k < 200; k++) begin
            send(ROW_W'($urandom_range(0, 3)), TAG_W'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/dram_req_sched.md
Name: dram_req_sched

Overview:
- Request scheduler placed directly upstream of the row-buffered DRAM model.
- Accepts row-read requests from a client through a valid/ready interface and holds them in a small queue.
- Issues one request at a time to the DRAM using a row-hit-first policy with a starvation cap.
- Returns each DRAM result to the client with the request tag and a hit indication.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- ROW_W, 4, row-number width; matches the DRAM row select.
- DATA_W, 32, data width; matches the DRAM output.
- TAG_W, 4, width of the client request tag.
- MAX_BYPASS, 2, maximum number of times the oldest entry may be overtaken by younger row-hit entries.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  client request present.
- req_ready  out  1  queue can accept a request; combinational, equal to (count < DEPTH).
- req_rno  in  ROW_W  requested row.
- req_tag  in  TAG_W  client tag, returned with the response.
- mem_valid  out  1  one-cycle issue strobe to the DRAM input_valid.
- mem_rno  out  ROW_W  row presented to the DRAM rno; held stable from issue until the response.
- mem_done  in  1  DRAM output_bit.
- mem_y  in  DATA_W  DRAM data output y.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  DATA_W  captured mem_y.
- rsp_tag  out  TAG_W  tag of the completed request.
- rsp_hit  out  1  request was issued as a predicted row hit.
- busy  out  1  high when the FSM is in ISSUE or WAIT.

Behaviour:
- Reset (asynchronous; may be asserted mid-operation):
  - Queue emptied; count=0.
  - FSM goes to IDLE.
  - open_vld=0 and bypass_cnt=0.
  - All registered outputs (mem_valid, mem_rno, rsp_valid, rsp_data, rsp_tag, rsp_hit, busy) are 0.
  - Any DRAM response still outstanding at reset is ignored.
- Enqueue:
  - Occurs on a rising edge with req_valid && req_ready.
  - The entry {rno, tag} is appended at the tail; entries are kept in age order (index 0 is oldest).
  - Enqueue and dequeue in the same edge are legal. Compaction happens first, then the new entry is placed at the new tail.
  - When full, req_ready=0 and the request is not taken.
- Selection (evaluated in IDLE with count>0):
  - hit = open_vld && entry.rno==open_row.
  - If bypass_cnt==MAX_BYPASS, select entry 0.
  - Otherwise select the oldest hit entry; if there is none, select entry 0.
  - If the selected index is not 0, bypass_cnt increments; if it is 0, bypass_cnt clears.
  - The selected entry is removed from the queue and its rno/tag/hit are latched.
  - open_row is set to the latched rno and open_vld is set to 1.
- FSM:
  - IDLE: when count>0, perform selection and go to ISSUE.
  - ISSUE: mem_valid=1 for exactly this one cycle, with mem_rno equal to the latched row. Next state is WAIT.
  - WAIT:
    - mem_done is ignored on the edge where the DRAM samples mem_valid, because its value is stale.
    - From the following edge on, the first sampled mem_done==1 completes the request.
    - On completion: rsp_data=mem_y, rsp_tag and rsp_hit are loaded from the latch, rsp_valid=1 for one cycle, and the FSM returns to IDLE.
- Timing:
  - Issue-to-response is at least 3 cycles (row hit).
  - A row miss waits as long as the DRAM requires; there is no timeout.
- Concurrency:
  - Only one request is outstanding at a time.
  - The queue keeps accepting new requests during ISSUE and WAIT.
- Tags are opaque: duplicate tags are legal and are returned unchanged.

Test Plan:
- Reset check: assert rst mid-stream → all outputs are 0 on the same cycle with no clock edge; req_ready=1 after release.
- Single request: rno=5, tag=1 → one mem_valid pulse with mem_rno=5; rsp_valid once with rsp_data=5, rsp_tag=1, rsp_hit=0.
- Reorder: row 3 open; queue holds [(7,t0), (3,t1), (3,t2)] → responses arrive in order t1, t2, t0; rsp_hit is 1, 1, 0.
- Starvation cap: MAX_BYPASS=2; row 3 open; queue holds [(7,t0), (3,t1), (3,t2), (3,t3)] → order is t1, t2, t0, t3; t3 has rsp_hit=0.
- Full queue: hold the DRAM in WAIT and push 5 requests → req_ready=0 after the 4th; the 5th is accepted on the first cycle after a dequeue, and nothing is lost or duplicated.
- Reset during WAIT: a later mem_done=1 produces no rsp_valid; the next request after release reports rsp_hit=0.
